ins_queue: RTL and testbench

INS_QUEUE -- requirements
Module: ins_queue

---
 rtl/ins_pkg.sv | 20 ++
 rtl/ins_queue_mem.sv | 32 +++
 rtl/ins_queue.sv | 102 ++++++++++
 tb/tb_ins_queue.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ins_pkg.sv
// ============================================================================
// Module : ins_pkg
// Brief  : Shared defaults and count-width derivation for the instruction queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ins_pkg;

    localparam int INS_W_DEF = 9;
    localparam int DEPTH_DEF = 4;

    // Count must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ins_queue_mem.sv
// ============================================================================
// Module : ins_queue_mem
// Brief  : DEPTH x INS_W storage, synchronous write, asynchronous read, no reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_queue_mem #(
    parameter int INS_W = 9,
    parameter int DEPTH = 4
) (
    input  logic                     iClk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [INS_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [INS_W-1:0]         rd_data
);

    logic [INS_W-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/ins_queue.sv
// ============================================================================
// Module : ins_queue
// Brief  : FIFO instruction queue with flush; optional same-cycle bypass when
//          built with INS_QUEUE_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_queue
    import ins_pkg::*;
#(
    parameter int INS_W = INS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic [INS_W-1:0]          iIns,
    input  logic                      iLoad,
    input  logic                      iNext,
    input  logic                      iFlush,
    output logic [INS_W-1:0]          oIns,
    output logic                      oValid,
    output logic                      oReady,
    output logic [cnt_w(DEPTH)-1:0]   oCount
);

    localparam int               CNT_W  = cnt_w(DEPTH);
    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ins_queue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [INS_W-1:0] head;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             store;

    assign empty = (count == '0);
    assign full  = (count == C_FULL);
    assign push  = iLoad & ~full;
    assign pop   = iNext & ~empty;

`ifdef INS_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass = empty & iLoad & ~iFlush;
    // A bypassed word consumed in the same cycle never enters storage.
    assign store  = push & ~(bypass & iNext);
    assign oValid = ~empty | bypass;
    assign oIns   = ~empty ? head : (bypass ? iIns : '0);
`else
    assign store  = push;
    assign oValid = ~empty;
    assign oIns   = ~empty ? head : '0;
`endif

    assign oReady = ~full;
    assign oCount = count;

    always_ff @(posedge iClk) begin
        if (!iRst_n || iFlush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    ins_queue_mem #(
        .INS_W (INS_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .iClk    (iClk),
        .we      (store & ~iFlush & iRst_n),
        .wr_addr (wr_ptr),
        .wr_data (iIns),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

endmodule

`default_nettype wire

// File: tb/tb_ins_queue.sv
// ============================================================================
// Module : tb_ins_queue
// Brief  : Self-checking bench for ins_queue against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ins_queue;

    localparam int INS_W = 9;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             iClk = 1'b0;
    logic             iRst_n;
    logic [INS_W-1:0] iIns;
    logic             iLoad;
    logic             iNext;
    logic             iFlush;
    logic [INS_W-1:0] oIns;
    logic             oValid;
    logic             oReady;
    logic [CW-1:0]    oCount;

    int checks = 0;
    int errors = 0;
    bit model_ok = 0;

    logic [INS_W-1:0] q[$];

    always #5 iClk = ~iClk;

    ins_queue #(
        .INS_W (INS_W),
        .DEPTH (DEPTH)
    ) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iIns   (iIns),
        .iLoad  (iLoad),
        .iNext  (iNext),
        .iFlush (iFlush),
        .oIns   (oIns),
        .oValid (oValid),
        .oReady (oReady),
        .oCount (oCount)
    );

    // One clock: apply inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic rst_n, input logic load, input logic next,
                        input logic flush, input logic [INS_W-1:0] ins);
        logic             byp;
        logic             exp_valid;
        logic [INS_W-1:0] exp_ins;
        logic             exp_ready;
        logic [CW-1:0]    exp_count;
        bit               do_push;
        bit               do_pop;
        iRst_n = rst_n;
        iLoad  = load;
        iNext  = next;
        iFlush = flush;
        iIns   = ins;
        @(negedge iClk);
        byp = 1'b0;
`ifdef INS_QUEUE_BYPASS_EN
        byp = (q.size() == 0) && load && !flush;
`endif
        exp_valid = (q.size() != 0) || byp;
        exp_ins   = (q.size() != 0) ? q[0] : (byp ? ins : '0);
        exp_ready = (q.size() != DEPTH);
        exp_count = CW'(q.size());
        if (model_ok) begin
            checks += 4;
            assert (oValid === exp_valid) else begin
                errors++;
                $error("FAIL valid observed=%0b expected=%0b t=%0t", oValid, exp_valid, $time);
            end
            assert (oIns === exp_ins) else begin
                errors++;
                $error("FAIL ins observed=%h expected=%h t=%0t", oIns, exp_ins, $time);
            end
            assert (oReady === exp_ready) else begin
                errors++;
                $error("FAIL ready observed=%0b expected=%0b t=%0t", oReady, exp_ready, $time);
            end
            assert (oCount === exp_count) else begin
                errors++;
                $error("FAIL count observed=%0d expected=%0d t=%0t", oCount, exp_count, $time);
            end
        end
        @(posedge iClk);
        if (!rst_n || flush) begin
            q.delete();
        end else if (!(byp && next)) begin
            do_push = load && (q.size() < DEPTH);
            do_pop  = next && (q.size() > 0);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(ins);
        end
        if (!rst_n) model_ok = 1;
        #1;
    endtask

    initial begin
        // Reset, then idle
        step(0, 0, 0, 0, '0);
        step(0, 1, 1, 1, 9'h1AA);
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);

        // Ordered pushes and pops
        step(1, 1, 0, 0, 9'h101);
        step(1, 1, 0, 0, 9'h0A5);
        step(1, 1, 0, 0, 9'h1FF);
        step(1, 0, 1, 0, '0);
        step(1, 0, 1, 0, '0);
        step(1, 0, 1, 0, '0);
        step(1, 0, 1, 0, '0);

        // Overfill: fifth word dropped
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, INS_W'(9'h010 + i));
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, '0);

        // Full with load+pop, then count=2 with load+pop
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, INS_W'(9'h020 + i));
        step(1, 1, 1, 0, 9'h0EE);
        step(1, 0, 1, 0, '0);
        step(1, 1, 1, 0, 9'h0DD);
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, '0);

        // Flush wins over load at count=3
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, INS_W'(9'h030 + i));
        step(1, 1, 1, 1, 9'h0BB);
        step(1, 0, 0, 0, '0);
        step(1, 1, 0, 0, 9'h055);
        step(1, 0, 0, 0, '0);
        step(1, 0, 1, 0, '0);

        // Empty-queue load, with and without a same-cycle pop
        step(1, 1, 0, 0, 9'h123);
        step(1, 0, 0, 0, '0);
        step(1, 0, 1, 0, '0);
        step(1, 1, 1, 0, 9'h123);
        step(1, 0, 0, 0, '0);

        // Reset mid-operation discards entries
        step(1, 1, 0, 0, 9'h0F0);
        step(1, 1, 0, 0, 9'h0F1);
        step(0, 0, 0, 0, '0);
        step(1, 1, 0, 0, 9'h0F2);
        step(1, 0, 0, 0, '0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step((r < 2) ? 1'b0 : 1'b1,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 (r >= 2 && r < 6) ? 1'b1 : 1'b0,
                 INS_W'($urandom_range(0, (1 << INS_W) - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
